jtdsp16_ram_port: RTL and testbench

Data-RAM responder for the JTDSP16 core. It services the read/write requests that the RAM address arithmetic unit issues from its pointer registers, and shares the same single-port RAM with a host/debug port through a fixed-priority arbiter with an anti-starvation guard. It sits between the RAM AAU/DAU datapath and the on-chip data RAM array, and returns registered read data with fixed one-slot latency.

---
 rtl/jtdsp16_ram_port_pkg.sv | 28 ++
 rtl/jtdsp16_ram_sp.sv | 28 ++
 rtl/jtdsp16_ram_port.sv | 136 +++++++++++++
 tb/tb_jtdsp16_ram_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_ram_port_pkg.sv
// Shared definitions for the JTDSP16 data-RAM port: default address width,
// grant encoding and the anti-starvation counter helper.
package jtdsp16_ram_port_pkg;

    localparam int JTDSP16_RAM_AW = 11;
    localparam int STARVE_W       = 4;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_AAU  = 2'd1,
        GNT_HOST = 2'd2
    } gnt_e;

    // Saturating increment of the host starvation counter.
    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] lim
    );
        logic [STARVE_W-1:0] nxt;
        if (cnt >= lim) begin
            nxt = lim;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jtdsp16_ram_sp.sv
// Single-port synchronous data RAM with a registered read port. Contents are
// deliberately not reset so that data survives a core reset.
module jtdsp16_ram_sp #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // One access per enabled clock: write the array or register the read word.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                q <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/jtdsp16_ram_port.sv
// Data-RAM responder: arbitrates AAU and host accesses onto one single-port RAM
// with AAU priority bounded by a starvation guard, and returns read data one slot later.
module jtdsp16_ram_port
    import jtdsp16_ram_port_pkg::*;
#(
    parameter int AW     = JTDSP16_RAM_AW,
    parameter int DW     = 16,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [15:0]   aau_addr,
    input  logic          aau_rd,
    input  logic          aau_wr,
    input  logic [DW-1:0] aau_din,
    output logic [DW-1:0] aau_dout,
    output logic          aau_dv,
    output logic          aau_stall,
    input  logic [AW-1:0] host_addr,
    input  logic          host_rd,
    input  logic          host_wr,
    input  logic [DW-1:0] host_din,
    output logic [DW-1:0] host_dout,
    output logic          host_ack
);

    localparam logic [STARVE_W-1:0] STARVE_L = STARVE_W'(STARVE);

    logic                aau_req_s;
    logic                host_req_s;
    gnt_e                gnt_s;
    logic [AW-1:0]       ram_addr_s;
    logic                ram_we_s;
    logic [DW-1:0]       ram_din_s;
    logic                rd_s;
    logic [DW-1:0]       ram_q_s;
    logic                host_rdv_s;
    logic                unused_addr_s;

    gnt_e                gnt_r;
    logic                rd_r;
    logic [STARVE_W-1:0] starve_r;
    logic [DW-1:0]       aau_hold_r;
    logic [DW-1:0]       host_hold_r;

    // Upper AAU address bits alias onto the array.
    assign unused_addr_s = ^aau_addr[15:AW];

    // Arbitration and RAM port steering for the current slot.
    always_comb begin
        aau_req_s  = aau_rd | aau_wr;
        host_req_s = (host_rd | host_wr) & ~host_ack;
        gnt_s      = GNT_IDLE;
        if (host_req_s && (!aau_req_s || starve_r == STARVE_L)) begin
            gnt_s = GNT_HOST;
        end else if (aau_req_s) begin
            gnt_s = GNT_AAU;
        end else begin
            gnt_s = GNT_IDLE;
        end

        ram_addr_s = aau_addr[AW-1:0];
        ram_we_s   = 1'b0;
        ram_din_s  = aau_din;
        rd_s       = 1'b0;
        case (gnt_s)
            GNT_HOST: begin
                ram_addr_s = host_addr;
                ram_we_s   = host_wr;
                ram_din_s  = host_din;
                rd_s       = host_rd & ~host_wr;
            end
            GNT_AAU: begin
                ram_addr_s = aau_addr[AW-1:0];
                ram_we_s   = aau_wr;
                ram_din_s  = aau_din;
                rd_s       = aau_rd & ~aau_wr;
            end
            default: begin
                ram_addr_s = aau_addr[AW-1:0];
                ram_we_s   = 1'b0;
                ram_din_s  = aau_din;
                rd_s       = 1'b0;
            end
        endcase
    end

    assign aau_stall = aau_req_s & (gnt_s == GNT_HOST);

    jtdsp16_ram_sp #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk  (clk),
        .cen  (cen),
        .addr (ram_addr_s),
        .we   (ram_we_s),
        .din  (ram_din_s),
        .q    (ram_q_s)
    );

    // The registered grant decides which port sees the RAM read word this slot.
    assign aau_dv     = (gnt_r == GNT_AAU) & rd_r;
    assign host_ack   = (gnt_r == GNT_HOST);
    assign host_rdv_s = host_ack & rd_r;
    assign aau_dout   = aau_dv ? ram_q_s : aau_hold_r;
    assign host_dout  = host_rdv_s ? ram_q_s : host_hold_r;

    // Slot state: registered grant, starvation counter and held read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r       <= GNT_IDLE;
            rd_r        <= 1'b0;
            starve_r    <= '0;
            aau_hold_r  <= '0;
            host_hold_r <= '0;
        end else if (cen) begin
            gnt_r <= gnt_s;
            rd_r  <= rd_s;
            if (host_req_s && gnt_s == GNT_AAU) begin
                starve_r <= starve_inc(starve_r, STARVE_L);
            end else begin
                starve_r <= '0;
            end
            // Capture the word being presented so it survives the next RAM access.
            if (aau_dv) begin
                aau_hold_r <= ram_q_s;
            end
            if (host_rdv_s) begin
                host_hold_r <= ram_q_s;
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16_ram_port.sv
// Randomized scoreboard bench for jtdsp16_ram_port: a slot-level reference
// model predicts grants, stalls and returned data; a monitor checks outputs.
module tb_jtdsp16_ram_port;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic [15:0] aau_addr;
    logic        aau_rd;
    logic        aau_wr;
    logic [15:0] aau_din;
    logic [15:0] aau_dout;
    logic        aau_dv;
    logic        aau_stall;
    logic [10:0] host_addr;
    logic        host_rd;
    logic        host_wr;
    logic [15:0] host_din;
    logic [15:0] host_dout;
    logic        host_ack;

    jtdsp16_ram_port #(.AW(11), .DW(16), .STARVE(STARVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .aau_addr  (aau_addr),
        .aau_rd    (aau_rd),
        .aau_wr    (aau_wr),
        .aau_din   (aau_din),
        .aau_dout  (aau_dout),
        .aau_dv    (aau_dv),
        .aau_stall (aau_stall),
        .host_addr (host_addr),
        .host_rd   (host_rd),
        .host_wr   (host_wr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .host_ack  (host_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
    } ent_t;

    ent_t aq[$];
    ent_t hq[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_mem [0:2047];
    logic [15:0] m_ahold;
    logic [15:0] m_hhold;
    logic        m_ack;
    int          m_starve;
    logic        last_stall;
    int          stall_cnt;
    int          first_stall;
    int          slot_idx;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One bench slot: inputs already driven; predict, check stall, enqueue expectations.
    task automatic slot();
        logic areq, hreq, hwin, awin;
        ent_t ea, eh;
        #1;
        areq = aau_rd | aau_wr;
        hreq = (host_rd | host_wr) & ~m_ack;
        hwin = hreq && (!areq || m_starve == STARVE);
        awin = !hwin && areq;
        chk("aau_stall", {15'd0, aau_stall}, {15'd0, areq & hwin});
        if (cen) begin
            if (areq && hwin) begin
                if (first_stall < 0) first_stall = slot_idx;
                stall_cnt++;
            end
            slot_idx++;
            ea.v = awin && aau_rd && !aau_wr;
            if (ea.v) m_ahold = m_mem[aau_addr[10:0]];
            ea.d = m_ahold;
            eh.v = hwin;
            if (hwin && host_rd && !host_wr) m_hhold = m_mem[host_addr];
            eh.d = m_hhold;
            aq.push_back(ea);
            hq.push_back(eh);
            if (awin && aau_wr) m_mem[aau_addr[10:0]] = aau_din;
            if (hwin && host_wr) m_mem[host_addr] = host_din;
            if (hreq && awin) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
            else m_starve = 0;
            m_ack = hwin;
            last_stall = areq & hwin;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        aau_rd = 1'b0; aau_wr = 1'b0; host_rd = 1'b0; host_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_aau_dv", {15'd0, aau_dv}, 16'd0);
        chk("rst_aau_dout", aau_dout, 16'd0);
        chk("rst_host_ack", {15'd0, host_ack}, 16'd0);
        chk("rst_host_dout", host_dout, 16'd0);
        aq.delete();
        hq.delete();
        m_ack = 1'b0; m_starve = 0; m_ahold = 16'd0; m_hhold = 16'd0; last_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per enabled slot; outputs must hold across cen=0 clocks.
    logic [15:0] x_ad, x_hd;
    logic        x_dv, x_ack;
    always @(posedge clk) begin
        logic c_at, r_at;
        ent_t e;
        c_at = cen;
        r_at = rst_n;
        #1;
        if (!r_at) begin
            x_dv = 1'b0; x_ad = 16'd0; x_ack = 1'b0; x_hd = 16'd0;
        end else begin
            if (c_at) begin
                if (aq.size() == 0 || hq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=%0d expected=1", aq.size());
                end else begin
                    e = aq.pop_front();
                    x_dv = e.v; x_ad = e.d;
                    e = hq.pop_front();
                    x_ack = e.v; x_hd = e.d;
                end
            end
            chk("aau_dv", {15'd0, aau_dv}, {15'd0, x_dv});
            chk("aau_dout", aau_dout, x_ad);
            chk("host_ack", {15'd0, host_ack}, {15'd0, x_ack});
            chk("host_dout", host_dout, x_hd);
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; cen = 1'b1;
        idle_inputs();
        aau_addr = 16'd0; aau_din = 16'd0; host_addr = 11'd0; host_din = 16'd0;
        m_ack = 1'b0; m_starve = 0; m_ahold = 16'd0; m_hhold = 16'd0;
        last_stall = 1'b0; stall_cnt = 0; first_stall = -1; slot_idx = 0;
        @(negedge clk);
        do_reset();

        // AAU write then read back in the next slot
        aau_wr = 1'b1; aau_addr = 16'h0005; aau_din = 16'h1234; slot();
        aau_wr = 1'b0; aau_rd = 1'b1; slot();
        aau_rd = 1'b0; slot();

        // aliased AAU write, host read of the low address
        aau_wr = 1'b1; aau_addr = 16'h0805; aau_din = 16'hBEEF; slot();
        aau_wr = 1'b0; slot();
        host_rd = 1'b1; host_addr = 11'h005;
        for (int i = 0; i < 6; i++) begin
            if (m_ack) host_rd = 1'b0;
            slot();
        end

        // fill a small working set
        for (int a = 0; a < 32; a++) begin
            aau_wr = 1'b1; aau_addr = 16'(a); aau_din = 16'($urandom); slot();
        end
        aau_wr = 1'b0; slot();

        // starvation: continuous AAU reads against a held host read
        stall_cnt = 0; first_stall = -1; slot_idx = 0;
        host_rd = 1'b1; host_addr = 11'h010;
        for (int i = 0; i < 8; i++) begin
            aau_rd = 1'b1; aau_addr = 16'($urandom_range(0, 31));
            if (m_ack) host_rd = 1'b0;
            slot();
        end
        aau_rd = 1'b0; host_rd = 1'b0; slot();
        chk("starve_first_stall_slot", 16'(first_stall), 16'd4);
        chk("starve_stall_count", 16'(stall_cnt), 16'd1);

        // host holds read through ack: recovery slot then a new access
        host_rd = 1'b1; host_addr = 11'h003;
        for (int i = 0; i < 5; i++) slot();
        host_rd = 1'b0; slot(); slot();

        // cen toggling during a read
        aau_rd = 1'b1; aau_addr = 16'h0007; slot();
        aau_rd = 1'b0; cen = 1'b0; slot(); slot(); slot();
        cen = 1'b1; slot();

        // reset right after a host read grant
        host_rd = 1'b1; host_addr = 11'h005; slot();
        host_rd = 1'b0;
        do_reset();
        slot(); slot();
        aau_rd = 1'b1; aau_addr = 16'h0005; slot();
        aau_addr = 16'h0010; slot();
        aau_rd = 1'b0; slot();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cen = ($urandom_range(0, 4) != 0);
            if (m_ack) begin
                host_rd = 1'b0; host_wr = 1'b0;
            end else if (!(host_rd | host_wr) && $urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, 4);
                host_rd = (n != 1); host_wr = (n == 1 || n == 4);
                host_addr = 11'($urandom_range(0, 31));
                host_din = 16'($urandom);
            end
            if (!last_stall) begin
                n = $urandom_range(0, 9);
                aau_rd = (n < 5 || n == 8); aau_wr = (n == 5 || n == 6 || n == 8);
                aau_addr = {5'($urandom), 6'd0, 5'($urandom)};
                aau_din = 16'($urandom);
            end
            slot();
        end
        cen = 1'b1; idle_inputs(); slot(); slot();
        chk("sb_drained", 16'(aq.size() + hq.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
